// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD pattern writer.
// Holds the KS0108 command opcodes, frame geometry constants, the
// controller state encoding and the chip-select helper used by the top.
package lcd_pkg;

  localparam int PATTERN_W      = 256;
  localparam int BYTES_PER_PAT  = 32;
  localparam int PATS_PER_FRAME = 32;

  localparam logic [7:0] CMD_DISP_ON    = 8'h3F;
  localparam logic [7:0] CMD_START_LINE = 8'hC0;
  localparam logic [7:0] CMD_PAGE       = 8'hB8;
  localparam logic [7:0] CMD_COL        = 8'h40;

  typedef enum logic [3:0] {
    ST_RST_HOLD  = 4'd0,
    ST_INIT_ON   = 4'd1,
    ST_INIT_LINE = 4'd2,
    ST_IDLE      = 4'd3,
    ST_FRAME     = 4'd4,
    ST_REQ       = 4'd5,
    ST_WAIT      = 4'd6,
    ST_SET_PAGE  = 4'd7,
    ST_SET_COL   = 4'd8,
    ST_DATA      = 4'd9,
    ST_NEXT      = 4'd10,
    ST_DONE      = 4'd11
  } state_t;

  // Chip select {CS2, CS1} for pattern k: bit 2 picks the right-hand chip.
  function automatic logic [1:0] chip_sel(input logic [4:0] k);
    return k[2] ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/lcd_write_strobe.sv
// One LCD bus write with fixed strobe timing.
// Ports: start launches a write of {di, cs, data}; the LCD pins are
// registered and held until the next write; LCD_EN is low for EN_HALF
// cycles, high for EN_HALF cycles, then low for one hold cycle in which
// done pulses. A write therefore occupies 2*EN_HALF+1 cycles.
module lcd_write_strobe #(
  parameter int EN_HALF = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       di,
  input  logic [1:0] cs,
  input  logic [7:0] data,
  output logic       done,
  output logic [7:0] lcd_data,
  output logic       lcd_di,
  output logic       lcd_en,
  output logic       lcd_cs1,
  output logic       lcd_cs2
);

  localparam int CNT_W = $clog2(2 * EN_HALF + 1);
  localparam logic [CNT_W-1:0] EN_RISE = CNT_W'(EN_HALF);
  localparam logic [CNT_W-1:0] EN_FALL = CNT_W'(2 * EN_HALF);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             active_r;

  assign cnt_inc_s = cnt_r + CNT_W'(1);

  // Strobe sequencer: latch the bus word on start, then walk EN low/high/hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r    <= '0;
      active_r <= 1'b0;
      done     <= 1'b0;
      lcd_data <= 8'h00;
      lcd_di   <= 1'b0;
      lcd_en   <= 1'b0;
      lcd_cs1  <= 1'b0;
      lcd_cs2  <= 1'b0;
    end else if (start && !active_r) begin
      cnt_r    <= '0;
      active_r <= 1'b1;
      done     <= 1'b0;
      lcd_data <= data;
      lcd_di   <= di;
      lcd_en   <= 1'b0;
      lcd_cs1  <= cs[0];
      lcd_cs2  <= cs[1];
    end else if (active_r) begin
      if (cnt_r == EN_FALL) begin
        // hold cycle has just been spent with done high
        active_r <= 1'b0;
        done     <= 1'b0;
      end else begin
        cnt_r  <= cnt_inc_s;
        lcd_en <= (cnt_inc_s >= EN_RISE) && (cnt_inc_s < EN_FALL);
        done   <= (cnt_inc_s == EN_FALL);
      end
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: rtl/lcd_pattern_writer.sv
// Consumer end of the 256-bit tile-pattern interface.
// Resets and initialises a 128x64 two-chip KS0108 LCD, then (while
// enable is high) refreshes whole frames: CLEAR restarts the generator,
// each of 32 patterns is requested with CALLFORPATTERN, latched, and
// written as a page/column command pair plus 32 data bytes.
// Ports: clk/reset, enable, PATTERN in; CLEAR, CALLFORPATTERN, LCD_* pins,
// busy and frame_done out.
module lcd_pattern_writer
  import lcd_pkg::*;
#(
  parameter int EN_HALF  = 4,
  parameter int PAT_WAIT = 2,
  parameter int RST_WAIT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [PATTERN_W-1:0] PATTERN,
  output logic                 CLEAR,
  output logic                 CALLFORPATTERN,
  output logic [7:0]           LCD_DATA,
  output logic                 LCD_DI,
  output logic                 LCD_RW,
  output logic                 LCD_EN,
  output logic                 LCD_CS1,
  output logic                 LCD_CS2,
  output logic                 LCD_RST,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int WAIT_MAX = (RST_WAIT > PAT_WAIT) ? RST_WAIT : PAT_WAIT;
  localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] RST_LAST = WAIT_W'(RST_WAIT - 1);
  localparam logic [WAIT_W-1:0] PAT_LAST = WAIT_W'(PAT_WAIT - 1);

  state_t                 state_r;
  state_t                 state_s;
  state_t                 after_s;
  logic [WAIT_W-1:0]      wait_r;
  logic [4:0]             k_r;
  logic [4:0]             byte_r;
  logic [PATTERN_W-1:0]   shadow_r;
  logic                   wr_active_r;
  logic                   write_s;
  logic                   start_s;
  logic                   wr_di_s;
  logic [1:0]             wr_cs_s;
  logic [7:0]             wr_data_s;
  logic                   wr_done_s;
  logic                   clear_r;
  logic                   cfp_r;
  logic                   busy_r;
  logic                   frame_done_r;
  logic                   lcd_rst_r;

  // Next-state decode and bus-write request for the write states.
  always_comb begin
    state_s   = state_r;
    after_s   = state_r;
    write_s   = 1'b0;
    start_s   = 1'b0;
    wr_di_s   = 1'b0;
    wr_cs_s   = chip_sel(k_r);
    wr_data_s = 8'h00;
    case (state_r)
      ST_RST_HOLD: begin
        if (wait_r == RST_LAST) state_s = ST_INIT_ON;
        else                    state_s = ST_RST_HOLD;
      end
      ST_INIT_ON: begin
        write_s   = 1'b1;
        wr_cs_s   = 2'b11;
        wr_data_s = CMD_DISP_ON;
        after_s   = ST_INIT_LINE;
      end
      ST_INIT_LINE: begin
        write_s   = 1'b1;
        wr_cs_s   = 2'b11;
        wr_data_s = CMD_START_LINE;
        after_s   = ST_IDLE;
      end
      ST_IDLE: begin
        if (enable) state_s = ST_FRAME;
        else        state_s = ST_IDLE;
      end
      ST_FRAME: state_s = ST_REQ;
      ST_REQ:   state_s = ST_WAIT;
      ST_WAIT: begin
        if (wait_r == PAT_LAST) state_s = ST_SET_PAGE;
        else                    state_s = ST_WAIT;
      end
      ST_SET_PAGE: begin
        write_s   = 1'b1;
        wr_data_s = CMD_PAGE | {5'b00000, k_r[4:3], k_r[1]};
        after_s   = ST_SET_COL;
      end
      ST_SET_COL: begin
        write_s   = 1'b1;
        wr_data_s = CMD_COL | {2'b00, k_r[0], 5'b00000};
        after_s   = ST_DATA;
      end
      ST_DATA: begin
        write_s   = 1'b1;
        wr_di_s   = 1'b1;
        wr_data_s = shadow_r[PATTERN_W-1 -: 8];
        if (byte_r == 5'(BYTES_PER_PAT - 1)) after_s = ST_NEXT;
        else                                 after_s = ST_DATA;
      end
      ST_NEXT: begin
        if (k_r == 5'(PATS_PER_FRAME - 1)) state_s = ST_DONE;
        else                               state_s = ST_REQ;
      end
      ST_DONE: begin
        if (enable) state_s = ST_FRAME;
        else        state_s = ST_IDLE;
      end
      default: state_s = ST_RST_HOLD;
    endcase
    // Write states launch one strobe, then advance when it reports done.
    if (write_s) begin
      if (!wr_active_r)   start_s = 1'b1;
      else if (wr_done_s) state_s = after_s;
      else                state_s = state_r;
    end else begin
      start_s = 1'b0;
    end
  end

  // Controller state, wait counter, pattern index and write tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_RST_HOLD;
      wait_r      <= '0;
      k_r         <= 5'd0;
      wr_active_r <= 1'b0;
    end else begin
      state_r <= state_s;
      if (state_s != state_r)                               wait_r <= '0;
      else if (state_r == ST_RST_HOLD || state_r == ST_WAIT) wait_r <= wait_r + WAIT_W'(1);
      else                                                  wait_r <= wait_r;
      if (state_r == ST_FRAME)                                        k_r <= 5'd0;
      else if (state_r == ST_NEXT && k_r != 5'(PATS_PER_FRAME - 1))  k_r <= k_r + 5'd1;
      else                                                            k_r <= k_r;
      if (start_s)        wr_active_r <= 1'b1;
      else if (wr_done_s) wr_active_r <= 1'b0;
      else                wr_active_r <= wr_active_r;
    end
  end

  // Pattern shadow: latched on the last wait cycle, shifted MSB-first per data byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_r <= '0;
      byte_r   <= 5'd0;
    end else if (state_r == ST_WAIT && wait_r == PAT_LAST) begin
      shadow_r <= PATTERN;
      byte_r   <= 5'd0;
    end else if (state_r == ST_DATA && wr_done_s) begin
      shadow_r <= {shadow_r[PATTERN_W-9:0], 8'h00};
      byte_r   <= byte_r + 5'd1;
    end else begin
      shadow_r <= shadow_r;
      byte_r   <= byte_r;
    end
  end

  // Status and handshake outputs, registered so they align with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clear_r      <= 1'b0;
      cfp_r        <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      lcd_rst_r    <= 1'b0;
    end else begin
      clear_r      <= (state_s == ST_FRAME);
      cfp_r        <= (state_s == ST_REQ);
      frame_done_r <= (state_s == ST_DONE);
      lcd_rst_r    <= (state_s != ST_RST_HOLD);
      busy_r       <= (state_s == ST_FRAME) || (state_s == ST_REQ) ||
                      (state_s == ST_WAIT) || (state_s == ST_SET_PAGE) ||
                      (state_s == ST_SET_COL) || (state_s == ST_DATA) ||
                      (state_s == ST_NEXT);
    end
  end

  lcd_write_strobe #(.EN_HALF(EN_HALF)) u_strobe (
    .clk      (clk),
    .reset    (reset),
    .start    (start_s),
    .di       (wr_di_s),
    .cs       (wr_cs_s),
    .data     (wr_data_s),
    .done     (wr_done_s),
    .lcd_data (LCD_DATA),
    .lcd_di   (LCD_DI),
    .lcd_en   (LCD_EN),
    .lcd_cs1  (LCD_CS1),
    .lcd_cs2  (LCD_CS2)
  );

  assign CLEAR          = clear_r;
  assign CALLFORPATTERN = cfp_r;
  assign busy           = busy_r;
  assign frame_done     = frame_done_r;
  assign LCD_RST        = lcd_rst_r;
  assign LCD_RW         = 1'b0;

endmodule

// File: tb/tb_lcd_pattern_writer.sv
// Self-checking bench for lcd_pattern_writer: a generator model answers each
// pattern request with a random pattern, and an expected-write queue built
// from the addressing rules is compared against every LCD_EN falling edge.
module tb_lcd_pattern_writer;

  localparam int EN_HALF  = 2;
  localparam int PAT_WAIT = 2;
  localparam int RST_WAIT = 16;
  localparam int LIMIT    = 10000;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b0;
  logic [255:0] PATTERN = '0;
  logic         CLEAR, CALLFORPATTERN, LCD_DI, LCD_RW, LCD_EN;
  logic         LCD_CS1, LCD_CS2, LCD_RST, busy, frame_done;
  logic [7:0]   LCD_DATA;

  int err_cnt = 0;
  int chk_cnt = 0;
  int cfp_cnt = 0;
  int clr_cnt = 0;
  int fd_cnt = 0;
  int data_cnt = 0;
  int gk = 0;
  int hi = 0;
  logic prev_en = 1'b0;
  logic first_fixed = 1'b1;
  logic [11:0] exp_q[$];

  lcd_pattern_writer #(.EN_HALF(EN_HALF), .PAT_WAIT(PAT_WAIT), .RST_WAIT(RST_WAIT)) dut (
    .clk(clk), .reset(reset), .enable(enable), .PATTERN(PATTERN),
    .CLEAR(CLEAR), .CALLFORPATTERN(CALLFORPATTERN), .LCD_DATA(LCD_DATA),
    .LCD_DI(LCD_DI), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN), .LCD_CS1(LCD_CS1),
    .LCD_CS2(LCD_CS2), .LCD_RST(LCD_RST), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r = '0;
    for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom())};
    return r;
  endfunction

  task automatic push_init();
    exp_q.push_back({1'b0, 1'b0, 2'b11, 8'h3F});
    exp_q.push_back({1'b0, 1'b0, 2'b11, 8'hC0});
  endtask

  // Expected writes for pattern k, derived from the tile addressing rules.
  task automatic push_pattern(input int k, input logic [255:0] p);
    int chip = (k / 4) % 2;
    int page = (k / 8) * 2 + (k / 2) % 2;
    int col  = (k % 2) * 32;
    logic [1:0] cs = (chip == 1) ? 2'b10 : 2'b01;
    logic [7:0] b;
    exp_q.push_back({1'b0, 1'b0, cs, 8'(184 + page)});
    exp_q.push_back({1'b0, 1'b0, cs, 8'(64 + col)});
    for (int i = 0; i < 32; i++) begin
      b = 8'((p >> (248 - 8 * i)) & 256'hFF);
      exp_q.push_back({1'b0, 1'b1, cs, b});
    end
  endtask

  // Pattern generator model: answers each request, scrambles PATTERN after the latch window.
  always begin
    logic [255:0] pat;
    @(posedge clk);
    #1;
    if (reset) begin
      gk = 0;
    end else begin
      if (CLEAR) gk = 0;
      if (CALLFORPATTERN) begin
        if (first_fixed && gk == 0) begin
          pat = {8'hFF, {30{8'h01}}, 8'hFF};
          first_fixed = 1'b0;
        end else begin
          pat = rand256();
        end
        PATTERN = pat;
        push_pattern(gk, pat);
        gk++;
        repeat (PAT_WAIT + 1) @(posedge clk);
        #1;
        PATTERN = rand256();
      end
    end
  end

  // Bus monitor: each LCD_EN falling edge is one write checked against the queue.
  always @(negedge clk) begin
    logic [11:0] obs;
    logic [11:0] exp;
    if (reset) begin
      prev_en = 1'b0;
      hi = 0;
    end else begin
      if (CLEAR) clr_cnt++;
      if (CALLFORPATTERN) cfp_cnt++;
      if (frame_done) fd_cnt++;
      if (CLEAR || CALLFORPATTERN) check_val("clr_cfp_excl", 32'(CLEAR & CALLFORPATTERN), 32'd0);
      if (LCD_EN) begin
        hi++;
      end else if (prev_en) begin
        check_val("en_high", 32'(hi), 32'(EN_HALF));
        hi = 0;
        if (LCD_DI) data_cnt++;
        obs = {LCD_RW, LCD_DI, LCD_CS2, LCD_CS1, LCD_DATA};
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 12'hFFF;
        check_val("write", 32'(obs), 32'(exp));
      end
      prev_en = LCD_EN;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check_val(tag, 32'({CLEAR, CALLFORPATTERN, LCD_DATA, LCD_DI, LCD_RW, LCD_EN,
                        LCD_CS1, LCD_CS2, LCD_RST, busy, frame_done}), 32'd0);
  endtask

  task automatic release_and_init(input string tag);
    int n = 0;
    reset = 1'b0;
    while (!LCD_RST && n < 64) begin step(); n++; end
    check_val({tag, "_rst_wait"}, 32'(n), 32'(RST_WAIT));
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin step(); n++; end
    check_val({tag, "_init_writes_left"}, 32'(exp_q.size()), 32'd0);
    repeat (10) step();
    check_val({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check_val({tag, "_idle_clear"}, 32'(clr_cnt), 32'd0);
  endtask

  task automatic wait_frame_done(input string tag);
    int n = 0;
    while (!frame_done && n < LIMIT) begin step(); n++; end
    check_val({tag, "_frame_done_seen"}, 32'(frame_done), 32'd1);
    check_val({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check_val({tag, "_cfp_count"}, 32'(cfp_cnt), 32'd32);
    check_val({tag, "_data_writes"}, 32'(data_cnt), 32'd1024);
    check_val({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int n;
    repeat (3) step();
    check_reset_outputs("reset_outputs");
    push_init();
    step();
    release_and_init("boot");

    // Frame 1: fixed first pattern, then random ones.
    cfp_cnt = 0; data_cnt = 0; fd_cnt = 0;
    enable = 1'b1;
    n = 0;
    while (!CLEAR && n < 50) begin step(); n++; end
    check_val("f1_clear", 32'(CLEAR), 32'd1);
    check_val("f1_busy", 32'(busy), 32'd1);
    wait_frame_done("f1");
    step();
    check_val("f1_next_clear", 32'(CLEAR), 32'd1);
    check_val("f1_fd_once", 32'(fd_cnt), 32'd1);

    // Frame 2: enable dropped at k=10, frame still completes, then idle.
    cfp_cnt = 0; data_cnt = 0; clr_cnt = 0;
    n = 0;
    while (gk < 11 && n < LIMIT) begin step(); n++; end
    enable = 1'b0;
    wait_frame_done("f2");
    step();
    check_val("f2_no_clear", 32'(CLEAR), 32'd0);
    repeat (20) step();
    check_val("f2_idle_busy", 32'(busy), 32'd0);
    check_val("f2_clear_count", 32'(clr_cnt), 32'd1);

    // Frame 3: reset asserted while LCD_EN is high mid-data.
    cfp_cnt = 0; data_cnt = 0;
    enable = 1'b1;
    n = 0;
    while (!(data_cnt >= 40 && LCD_EN) && n < LIMIT) begin step(); n++; end
    check_val("f3_en_high_before_reset", 32'(LCD_EN), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_val("f3_en_async_drop", 32'(LCD_EN), 32'd0);
    check_reset_outputs("f3_reset_outputs");
    enable = 1'b0;
    exp_q.delete();
    push_init();
    repeat (3) step();
    clr_cnt = 0;
    release_and_init("reinit");

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
